lcd_bus_responder: RTL and testbench
====================================

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 Parameter BUSY_CYC, default 40, sets the busy-flag duration in CLK cycles for ordinary commands and data writes.
REQ-002 Parameter CLR_CYC, default 1600, sets the busy duration in CLK cycles for clear display and return home; it SHALL be at least 40.
REQ-003 CLK  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 LCD_E  input  1  bus enable strobe from the LCD writer; asynchronous to CLK.
REQ-006 LCD_RS  input  1  register select: 0 = instruction, 1 = data.
REQ-007 LCD_RW  input  1  direction: 0 = write, 1 = read.
REQ-008 LCD_DATA  input  8  bus write data.
REQ-009 LCD_DOUT  output  8  read data returned on the bus.
REQ-010 BUSY  output  1  busy flag.
REQ-011 RD_ADDR  input  5  side-port index into the character buffer: bit4 = line, bits 3:0 = column.
REQ-012 RD_CHAR  output  8  character at RD_ADDR, combinational from the buffer.
REQ-013 DISP_ON, CURSOR_ON, BLINK_ON  output  1 each  display-control state bits.
REQ-014 OVERRUN  output  1  sticky flag; set when a write arrives while BUSY=1.

Function
REQ-015 LCD_E, LCD_RS, LCD_RW and LCD_DATA SHALL pass through a two-stage CLK synchronizer.
REQ-016 A bus transaction SHALL commit on the detected falling edge of the synchronized LCD_E, using the synchronized RS, RW and DATA values.
REQ-017 A commit SHALL take effect exactly 3 CLK after the raw LCD_E falls.
REQ-018 The 7-bit address counter AC SHALL map to a buffer index as {AC[6], AC[3:0]}.
REQ-019 The character buffer SHALL hold 32 entries of 8 bits: line 0 at DDRAM 0x00-0x0F, line 1 at 0x40-0x4F.
REQ-020 An instruction write (RS=0, RW=0) SHALL be decoded by its highest set bit, as follows:
  - 1xxxxxxx (set DDRAM address): AC <= {D[6], 2'b00, D[3:0]}.
  - 001xxxxx (function set): D[4:2] stored internally; no other effect.
  - 0001xxxx (cursor/display shift): accepted, no effect.
  - 00001DCB (display control): DISP_ON <= D, CURSOR_ON <= C, BLINK_ON <= B.
  - 000001IS (entry mode): the increment bit <= I; S is stored but has no effect.
  - 0000001x (return home): AC <= 0x00.
  - 00000001 (clear display): AC <= 0x00, increment bit <= 1, all 32 entries <= 0x20.
  - 0x00: ignored; BUSY is not raised.
REQ-021 Clear display SHALL write one buffer entry per CLK, from index 0 to 31, completing within 32 CLK of the commit.
REQ-022 A data write (RS=1, RW=0) SHALL store DATA at buffer[AC] and then step AC.
REQ-023 When the increment bit is 1, AC SHALL step upward: +1, with 0x0F -> 0x40 and 0x4F -> 0x00.
REQ-024 When the increment bit is 0, AC SHALL step downward: -1, with 0x40 -> 0x0F and 0x00 -> 0x4F.
REQ-025 BUSY SHALL rise in the commit cycle and stay high for CLR_CYC cycles after clear or return home, and for BUSY_CYC cycles after any other accepted write.
REQ-026 A write committed while BUSY=1 SHALL be discarded and SHALL set OVERRUN.
REQ-027 While the synchronized RW=1 and RS=0, LCD_DOUT SHALL equal {BUSY, AC}.
REQ-028 While the synchronized RW=1 and RS=1, LCD_DOUT SHALL equal buffer[AC].
REQ-029 A data read commit SHALL step AC by the same rules as a data write, and SHALL be allowed even while BUSY=1.
REQ-030 While the synchronized RW=0, LCD_DOUT SHALL be 0x00.
REQ-031 When a side-port read and a commit land in the same cycle, RD_CHAR SHALL show the pre-commit value.

Reset
REQ-032 RST low SHALL asynchronously clear, with no clearing sequence: the synchronizers, AC=0x00, increment bit=1, DISP_ON=0, CURSOR_ON=0, BLINK_ON=0, BUSY=0, OVERRUN=0 and LCD_DOUT=0x00.
REQ-033 RST low SHALL set all 32 buffer entries to 0x20 asynchronously.
REQ-034 RST asserted during a clear sequence or busy countdown SHALL abort it immediately.
REQ-035 No commit SHALL be generated by the first LCD_E sample after RST is released.

Structure
REQ-036 Shared package lcd_pkg SHALL hold the instruction opcode masks, the blank character 0x20, and the line base addresses 0x00 and 0x40.
REQ-037 Sub-module lcd_bus_sync SHALL contain the two-stage synchronizer and the falling-edge detector; all decode logic, AC, buffer and busy counter SHALL stay in the top module.

Verification
REQ-038 Write 0x80, then data 0x41, 0x42 -> buffer[0]=0x41, buffer[1]=0x42, AC=0x02.
REQ-039 Write 0x8F, then data 0x5A -> buffer[15]=0x5A, AC=0x40.
REQ-040 Write 0x04, 0x80, then data 0x31 -> buffer[0]=0x31, AC=0x4F.
REQ-041 Write data 0x33 and, 10 CLK after its commit, write data 0x34 (BUSY_CYC=40) -> 0x34 discarded, OVERRUN=1, BUSY high for exactly 40 CLK.
REQ-042 Write 0x01 after filling the buffer -> all 32 entries = 0x20 within 32 CLK, BUSY high for 1600 CLK, then a status read returns LCD_DOUT=0x00.
REQ-043 Pull RST low 5 CLK into a clear -> BUSY=0 and all entries = 0x20 immediately; a following 0x0C write -> DISP_ON=1, CURSOR_ON=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD bus responder: instruction masks,
// the blank character, DDRAM line bases and the decoded instruction kinds.
package lcd_pkg;

  localparam logic [7:0] OP_SET_DDRAM  = 8'h80;
  localparam logic [7:0] OP_FUNC_SET   = 8'h20;
  localparam logic [7:0] OP_SHIFT      = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MODE = 8'h04;
  localparam logic [7:0] OP_HOME       = 8'h02;
  localparam logic [7:0] OP_CLEAR      = 8'h01;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_SET_DDRAM,
    CMD_FUNC_SET,
    CMD_SHIFT,
    CMD_DISP_CTRL,
    CMD_ENTRY_MODE,
    CMD_HOME,
    CMD_CLEAR
  } cmd_e;

endpackage

// File: rtl/lcd_bus_sync.sv
// Brings the asynchronous LCD bus into the clk domain and flags the
// falling edge of the enable strobe as a one-cycle commit pulse.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       commit,
  output logic       rs_sync,
  output logic       rw_sync,
  output logic [7:0] data_sync
);

  logic       e_p0, e_p1, e_p2;
  logic       rs_p0, rs_p1;
  logic       rw_p0, rw_p1;
  logic [7:0] data_p0, data_p1;

  // stage p0/p1: two-flop synchronizer; p2 is the edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_p0    <= 1'b0;
      e_p1    <= 1'b0;
      e_p2    <= 1'b0;
      rs_p0   <= 1'b0;
      rs_p1   <= 1'b0;
      rw_p0   <= 1'b0;
      rw_p1   <= 1'b0;
      data_p0 <= 8'h00;
      data_p1 <= 8'h00;
    end else begin
      e_p0    <= lcd_e;
      e_p1    <= e_p0;
      e_p2    <= e_p1;
      rs_p0   <= lcd_rs;
      rs_p1   <= rs_p0;
      rw_p0   <= lcd_rw;
      rw_p1   <= rw_p0;
      data_p0 <= lcd_data;
      data_p1 <= data_p0;
    end
  end

  // History resets low, so the first sample after reset can never look like a fall.
  assign commit    = e_p2 & ~e_p1;
  assign rs_sync   = rs_p1;
  assign rw_sync   = rw_p1;
  assign data_sync = data_p1;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: decodes committed bus writes/reads, keeps the
// address counter, 2x16 character buffer, display-control bits and busy flag.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC = 40,
  parameter int CLR_CYC  = 1600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] LCD_DOUT,
  output logic       BUSY,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       OVERRUN
);

  localparam int MAX_CYC = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             commit, rs_s, rw_s;
  logic [7:0]       data_s;
  cmd_e             cmd;
  logic [6:0]       ac;
  logic             inc;
  logic [CNT_W-1:0] busy_cnt;
  logic             clr_active;
  logic [4:0]       clr_idx;
  logic [4:0]       idx;
  logic [7:0]       char_buf [32];
  logic [2:0]       func_bits_unused;
  logic             entry_shift_unused;
  logic             wr, rd_data, accept, long_busy;

  lcd_bus_sync u_sync (
    .clk       (CLK),
    .rst_n     (RST),
    .lcd_e     (LCD_E),
    .lcd_rs    (LCD_RS),
    .lcd_rw    (LCD_RW),
    .lcd_data  (LCD_DATA),
    .commit    (commit),
    .rs_sync   (rs_s),
    .rw_sync   (rw_s),
    .data_sync (data_s)
  );

  // Address counter step with wrap between the two 16-column lines.
  function automatic logic [6:0] ac_step(input logic [6:0] cur, input logic up);
    logic [6:0] nxt;
    if (up) begin
      if (cur == LINE0_BASE + 7'h0F)      nxt = LINE1_BASE;
      else if (cur == LINE1_BASE + 7'h0F) nxt = LINE0_BASE;
      else                                nxt = cur + 7'd1;
    end else begin
      if (cur == LINE1_BASE)              nxt = LINE0_BASE + 7'h0F;
      else if (cur == LINE0_BASE)         nxt = LINE1_BASE + 7'h0F;
      else                                nxt = cur - 7'd1;
    end
    return nxt;
  endfunction

  always_comb begin
    cmd = CMD_NONE;
    if (|(data_s & OP_SET_DDRAM))       cmd = CMD_SET_DDRAM;
    else if (|(data_s & OP_FUNC_SET))   cmd = CMD_FUNC_SET;
    else if (|(data_s & OP_SHIFT))      cmd = CMD_SHIFT;
    else if (|(data_s & OP_DISP_CTRL))  cmd = CMD_DISP_CTRL;
    else if (|(data_s & OP_ENTRY_MODE)) cmd = CMD_ENTRY_MODE;
    else if (|(data_s & OP_HOME))       cmd = CMD_HOME;
    else if (|(data_s & OP_CLEAR))      cmd = CMD_CLEAR;
  end

  assign idx       = {ac[6], ac[3:0]};
  assign BUSY      = (busy_cnt != '0);
  assign wr        = commit & ~rw_s;
  assign rd_data   = commit & rw_s & rs_s;
  assign accept    = wr & ~BUSY & (rs_s | (cmd != CMD_NONE));
  assign long_busy = ~rs_s & ((cmd == CMD_HOME) | (cmd == CMD_CLEAR));

  always_comb begin
    LCD_DOUT = 8'h00;
    if (rw_s) LCD_DOUT = rs_s ? char_buf[idx] : {BUSY, ac};
  end

  assign RD_CHAR = char_buf[RD_ADDR];

  // commit stage: all architectural state updates on the commit edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ac                 <= LINE0_BASE;
      inc                <= 1'b1;
      DISP_ON            <= 1'b0;
      CURSOR_ON          <= 1'b0;
      BLINK_ON           <= 1'b0;
      OVERRUN            <= 1'b0;
      busy_cnt           <= '0;
      clr_active         <= 1'b0;
      clr_idx            <= 5'd0;
      func_bits_unused   <= 3'b000;
      entry_shift_unused <= 1'b0;
      for (int i = 0; i < 32; i++) char_buf[i] <= BLANK_CHAR;
    end else begin
      if (BUSY) busy_cnt <= busy_cnt - CNT_W'(1);

      // Clear sweeps one entry per cycle; entry 0 is written on the commit edge.
      if (clr_active) begin
        char_buf[clr_idx] <= BLANK_CHAR;
        clr_idx           <= clr_idx + 5'd1;
        if (clr_idx == 5'd31) clr_active <= 1'b0;
      end

      if (wr && BUSY) OVERRUN <= 1'b1;

      if (rd_data) ac <= ac_step(ac, inc);

      if (accept) begin
        busy_cnt <= long_busy ? CNT_W'(CLR_CYC) : CNT_W'(BUSY_CYC);
        if (rs_s) begin
          char_buf[idx] <= data_s;
          ac            <= ac_step(ac, inc);
        end else begin
          case (cmd)
            CMD_SET_DDRAM:  ac <= {data_s[6], 2'b00, data_s[3:0]};
            CMD_FUNC_SET:   func_bits_unused <= data_s[4:2];
            CMD_DISP_CTRL: begin
              DISP_ON   <= data_s[2];
              CURSOR_ON <= data_s[1];
              BLINK_ON  <= data_s[0];
            end
            CMD_ENTRY_MODE: begin
              inc                <= data_s[1];
              entry_shift_unused <= data_s[0];
            end
            CMD_HOME:       ac <= LINE0_BASE;
            CMD_CLEAR: begin
              ac          <= LINE0_BASE;
              inc         <= 1'b1;
              char_buf[0] <= BLANK_CHAR;
              clr_idx     <= 5'd1;
              clr_active  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with hand-computed expectations.
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [7:0] lcd_dout;
  logic       busy;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       disp_on, cursor_on, blink_on, overrun;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_bus_responder dut (
    .CLK       (clk),
    .RST       (rst_n),
    .LCD_E     (lcd_e),
    .LCD_RS    (lcd_rs),
    .LCD_RW    (lcd_rw),
    .LCD_DATA  (lcd_data),
    .LCD_DOUT  (lcd_dout),
    .BUSY      (busy),
    .RD_ADDR   (rd_addr),
    .RD_CHAR   (rd_char),
    .DISP_ON   (disp_on),
    .CURSOR_ON (cursor_on),
    .BLINK_ON  (blink_on),
    .OVERRUN   (overrun)
  );

  // Returns 1 ns after the commit edge (3rd rising edge after E falls).
  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s wait_idle: BUSY still %b after %0d cycles", name, busy, n);
      errors++;
    end
  endtask

  task automatic wr_idle(input logic rs, input logic [7:0] d);
    bus_cycle(rs, 1'b0, d);
    wait_idle("wr_idle");
  endtask

  task automatic read_status(output logic [7:0] v);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1;
    repeat (3) @(posedge clk);
    #1 v = lcd_dout;
    @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, output logic [7:0] v);
    rd_addr = a;
    #1 v = rd_char;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h0F; rd_addr = 5'd0;
    #12;
    checks++;
    if ({busy, overrun, disp_on, cursor_on, blink_on} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {busy, overrun, disp_on, cursor_on, blink_on});
      errors++;
    end
    checks++;
    if (lcd_dout !== 8'h00) begin
      $display("FAIL reset_dout: got %h expected 00", lcd_dout); errors++;
    end
    peek(5'd31, v);
    checks++;
    if (v !== 8'h20) begin
      $display("FAIL reset_buf31: got %h expected 20", v); errors++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || disp_on !== 1'b0) begin
      $display("FAIL reset_release_no_commit: busy=%b disp_on=%b expected 0 0", busy, disp_on);
      errors++;
    end
    read_status(v);
    checks++;
    if (v !== 8'h00) begin
      $display("FAIL reset_status: got %h expected 00", v); errors++;
    end
  endtask

  task automatic test_commit_latency();
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h0F; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (disp_on !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL latency_early: disp_on=%b busy=%b expected 0 0 two edges after fall", disp_on, busy);
      errors++;
    end
    @(posedge clk); #1;
    checks++;
    if ({disp_on, cursor_on, blink_on, busy} !== 4'b1111) begin
      $display("FAIL latency_commit: got %b expected 1111", {disp_on, cursor_on, blink_on, busy});
      errors++;
    end
    wait_idle("latency");
  endtask

  task automatic test_data_write();
    logic [7:0] v0, v1, s;
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b1, 8'h41);
    wr_idle(1'b1, 8'h42);
    peek(5'd0, v0);
    peek(5'd1, v1);
    checks++;
    if ({v0, v1} !== 16'h4142) begin
      $display("FAIL data_write_buf: got %h expected 4142", {v0, v1}); errors++;
    end
    read_status(s);
    checks++;
    if (s !== 8'h02) begin
      $display("FAIL data_write_ac: got %h expected 02", s); errors++;
    end
  endtask

  task automatic test_data_read();
    logic [7:0] s;
    bus_cycle(1'b0, 1'b0, 8'h81);
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lcd_dout !== 8'h42) begin
      $display("FAIL data_read_dout: got %h expected 42", lcd_dout); errors++;
    end
    bus_cycle(1'b1, 1'b1, 8'h00);
    checks++;
    if (lcd_dout !== 8'h20 || overrun !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL data_read_while_busy: dout=%h overrun=%b busy=%b expected 20 0 1", lcd_dout, overrun, busy);
      errors++;
    end
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (lcd_dout !== 8'h00) begin
      $display("FAIL dout_write_mode: got %h expected 00", lcd_dout); errors++;
    end
    wait_idle("data_read");
    read_status(s);
    checks++;
    if (s !== 8'h02) begin
      $display("FAIL data_read_ac: got %h expected 02", s); errors++;
    end
  endtask

  task automatic test_line_wrap();
    logic [7:0] v, s;
    wr_idle(1'b0, 8'h8F);
    wr_idle(1'b1, 8'h5A);
    peek(5'd15, v);
    read_status(s);
    checks++;
    if ({v, s} !== 16'h5A40) begin
      $display("FAIL wrap_0f: got %h expected 5a40", {v, s}); errors++;
    end
    wr_idle(1'b0, 8'hCF);
    wr_idle(1'b1, 8'h77);
    peek(5'd31, v);
    read_status(s);
    checks++;
    if ({v, s} !== 16'h7700) begin
      $display("FAIL wrap_4f: got %h expected 7700", {v, s}); errors++;
    end
  endtask

  task automatic test_decrement();
    logic [7:0] v, s;
    wr_idle(1'b0, 8'h04);
    wr_idle(1'b0, 8'h80);
    wr_idle(1'b1, 8'h31);
    peek(5'd0, v);
    read_status(s);
    checks++;
    if ({v, s} !== 16'h314F) begin
      $display("FAIL dec_00: got %h expected 314f", {v, s}); errors++;
    end
    wr_idle(1'b0, 8'hC0);
    wr_idle(1'b1, 8'h32);
    peek(5'd16, v);
    read_status(s);
    checks++;
    if ({v, s} !== 16'h320F) begin
      $display("FAIL dec_40: got %h expected 320f", {v, s}); errors++;
    end
    wr_idle(1'b0, 8'h06);
  endtask

  task automatic test_overrun();
    logic [7:0] v5, v6, s;
    int unsigned c0;
    wr_idle(1'b0, 8'h85);
    bus_cycle(1'b1, 1'b0, 8'h33);
    c0 = cyc;
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b0) begin
      $display("FAIL overrun_first: busy=%b overrun=%b expected 1 0", busy, overrun); errors++;
    end
    repeat (4) @(posedge clk);
    bus_cycle(1'b1, 1'b0, 8'h34);
    checks++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_flag: got %b expected 1 (gap %0d cycles)", overrun, cyc - c0); errors++;
    end
    while (busy && (cyc - c0) < 200) begin
      @(posedge clk); #1;
    end
    checks++;
    if (cyc - c0 !== 40) begin
      $display("FAIL overrun_busy_len: got %0d expected 40", cyc - c0); errors++;
    end
    peek(5'd5, v5);
    peek(5'd6, v6);
    read_status(s);
    checks++;
    if ({v5, v6, s} !== 24'h332006) begin
      $display("FAIL overrun_discard: got %h expected 332006", {v5, v6, s}); errors++;
    end
  endtask

  task automatic test_clear();
    logic [7:0] v, s;
    int unsigned c0;
    int bad;
    wr_idle(1'b0, 8'h80);
    for (int i = 0; i < 32; i++) wr_idle(1'b1, 8'h40 + 8'(i));
    peek(5'd20, v);
    checks++;
    if (v !== 8'h54) begin
      $display("FAIL clear_fill: got %h expected 54", v); errors++;
    end
    wr_idle(1'b0, 8'h04);
    bus_cycle(1'b0, 1'b0, 8'h01);
    c0 = cyc;
    repeat (31) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL clear_entries: %0d entries not 20 after 31 cycles, expected 0", bad); errors++;
    end
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL clear_busy_mid: got %b expected 1", busy); errors++;
    end
    while (busy && (cyc - c0) < 3000) begin
      @(posedge clk); #1;
    end
    checks++;
    if (cyc - c0 !== 1600) begin
      $display("FAIL clear_busy_len: got %0d expected 1600", cyc - c0); errors++;
    end
    read_status(s);
    checks++;
    if (s !== 8'h00) begin
      $display("FAIL clear_status: got %h expected 00", s); errors++;
    end
    wr_idle(1'b1, 8'h61);
    read_status(s);
    checks++;
    if (s !== 8'h01) begin
      $display("FAIL clear_inc_restored: got %h expected 01", s); errors++;
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] v;
    int bad;
    wr_idle(1'b0, 8'hCF);
    wr_idle(1'b1, 8'h7E);
    bus_cycle(1'b0, 1'b0, 8'h01);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL abort_flags: busy=%b overrun=%b expected 0 0", busy, overrun); errors++;
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL abort_entries: %0d entries not 20, expected 0", bad); errors++;
    end
    @(negedge clk) rst_n = 1'b1;
    bus_cycle(1'b0, 1'b0, 8'h0C);
    checks++;
    if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
      $display("FAIL abort_disp_ctrl: got %b expected 100", {disp_on, cursor_on, blink_on}); errors++;
    end
    wait_idle("abort");
  endtask

  initial begin
    test_reset();
    test_commit_latency();
    test_data_write();
    test_data_read();
    test_line_wrap();
    test_decrement();
    test_overrun();
    test_clear();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
